// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and the parity helper,
// used by both the transmitter and the receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        START_BIT  = 3'd1,
        DATA_BIT   = 3'd2,
        PARITY_BIT = 3'd3,
        STOP_BIT   = 3'd4
    } uart_state_t;

    // Widest payload the parity helper handles; narrower data is zero-extended.
    localparam int PARITY_MAX_WIDTH = 32;

    // Even parity is the XOR of all data bits; odd parity is its inverse.
    function automatic logic calc_parity(input logic [PARITY_MAX_WIDTH-1:0] data,
                                         input logic                        odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-cycle timer: counts 0..CLKS_PER_BIT-1 and strobes bit_done_o on the
// last count of every serial bit. clear_i holds the count at zero.
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic clear_i,
    output logic bit_done_o
);

    localparam int              CNT_W   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;

    assign bit_done_o = !clear_i && (cnt_q == CNT_MAX);

    // Free-running bit counter that wraps on bit_done and parks at zero when cleared.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else if (clear_i || bit_done_o) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter with an AXI-Stream style input: start bit, DATA_WIDTH data
// bits LSB first, optional parity bit, one stop bit. tx_o is registered, so
// the line lags the FSM state by one clock.
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic [DATA_WIDTH-1:0] slv_axis_tdata_i,
    input  logic                  slv_axis_tvalid_i,
    output logic                  slv_axis_tready_o,
    output logic                  tx_o,
    output logic                  busy_o
);

    localparam int              IDX_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

    uart_state_t           state_q;
    uart_state_t           state_d;
    logic [DATA_WIDTH-1:0] shift_q;
    logic [IDX_W-1:0]      idx_q;
    logic                  parity_q;
    logic                  bit_done;
    logic                  accept;

    assign accept = slv_axis_tready_o && slv_axis_tvalid_i;

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_gen (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .clear_i    (state_q == IDLE),
        .bit_done_o (bit_done)
    );

    // State register; reset aborts any frame in flight.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic plus handshake/busy flags; unknown encodings fall back to IDLE.
    always_comb begin
        state_d           = IDLE;
        slv_axis_tready_o = 1'b0;
        busy_o            = 1'b1;
        case (state_q)
            IDLE: begin
                slv_axis_tready_o = 1'b1;
                busy_o            = 1'b0;
                state_d           = slv_axis_tvalid_i ? START_BIT : IDLE;
            end
            START_BIT: begin
                state_d = bit_done ? DATA_BIT : START_BIT;
            end
            DATA_BIT: begin
                state_d = DATA_BIT;
                if (bit_done && (idx_q == IDX_LAST)) begin
                    state_d = (PARITY_EN != 0) ? PARITY_BIT : STOP_BIT;
                end
            end
            PARITY_BIT: begin
                state_d = bit_done ? STOP_BIT : PARITY_BIT;
            end
            STOP_BIT: begin
                state_d = bit_done ? IDLE : STOP_BIT;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Payload capture, shifting, bit index and the registered serial line.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            shift_q  <= '0;
            idx_q    <= '0;
            parity_q <= 1'b0;
            tx_o     <= 1'b1;
        end else begin
            if (accept) begin
                shift_q  <= slv_axis_tdata_i;
                parity_q <= calc_parity(PARITY_MAX_WIDTH'(slv_axis_tdata_i), 1'(PARITY_ODD));
                idx_q    <= '0;
            end else if ((state_q == DATA_BIT) && bit_done) begin
                shift_q <= shift_q >> 1;
                idx_q   <= (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
            end

            case (state_q)
                START_BIT:  tx_o <= 1'b0;
                DATA_BIT:   tx_o <= shift_q[0];
                PARITY_BIT: tx_o <= parity_q;
                default:    tx_o <= 1'b1;
            endcase
        end
    end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning payload bits per frame.
REQ-002 SHALL have parameter CLKS_PER_BIT, default 16, meaning clk_i cycles per serial bit (legal range >= 2).
REQ-003 SHALL have parameter PARITY_EN, default 1, meaning 1 = parity bit inserted, 0 = no parity bit.
REQ-004 SHALL have parameter PARITY_ODD, default 0, meaning 0 = even parity, 1 = odd parity.
REQ-005 SHALL have port clk_i, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst_n_i, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port slv_axis_tdata_i, input, DATA_WIDTH bits: the byte to transmit.
REQ-008 SHALL have port slv_axis_tvalid_i, input, 1 bit: upstream data valid.
REQ-009 SHALL have port slv_axis_tready_o, output, 1 bit: block can accept a byte.
REQ-010 SHALL have port tx_o, output, 1 bit: serial line, idle high.
REQ-011 SHALL have port busy_o, output, 1 bit: frame in progress.

Function
REQ-012 SHALL implement FSM states IDLE, START_BIT, DATA_BIT, PARITY_BIT, STOP_BIT.
REQ-013 SHALL hold slv_axis_tready_o = 1 only in IDLE and 0 in all other states.
REQ-014 SHALL accept a byte on a rising edge where slv_axis_tvalid_i & slv_axis_tready_o, latch tdata into a shift register, compute parity from the latched data, clear the bit-cycle counter, and enter START_BIT.
REQ-015 SHALL drive tx_o from a flop: 0 in START_BIT, shift-register LSB in DATA_BIT, parity in PARITY_BIT, and 1 in STOP_BIT/IDLE; tx_o falls on the first edge after the handshake edge.
REQ-016 SHALL hold every serial bit for exactly CLKS_PER_BIT cycles, timed by a counter running 0..CLKS_PER_BIT-1; a bit_done strobe is generated at count CLKS_PER_BIT-1.
REQ-017 SHALL send data LSB first and shift right on each DATA_BIT bit_done; a bit index 0..DATA_WIDTH-1 advances on bit_done.
REQ-018 SHALL move from DATA_BIT on bit_done with index DATA_WIDTH-1 to PARITY_BIT if PARITY_EN=1, else directly to STOP_BIT.
REQ-019 SHALL set parity = XOR of the data bits when PARITY_ODD=0, and its inverse when PARITY_ODD=1.
REQ-020 SHALL return from STOP_BIT to IDLE on bit_done, with a single stop bit.
REQ-021 SHALL produce a frame length of (2 + DATA_WIDTH + PARITY_EN) * CLKS_PER_BIT cycles; the minimum handshake-to-handshake period is frame length + 1 cycle.
REQ-022 SHALL ignore tvalid and tdata changes while not in IDLE; latched data SHALL be unaffected.
REQ-023 SHALL not start a frame in IDLE while tvalid = 0; tx_o SHALL stay 1 indefinitely.
REQ-024 SHALL assert busy_o = 1 in every state except IDLE.
REQ-025 SHALL treat any undefined state encoding as IDLE on the next edge, with tx_o = 1.

Reset
REQ-026 SHALL, while rst_n_i = 0, force state = IDLE, tx_o = 1, slv_axis_tready_o = 1, busy_o = 0, and clear counters, bit index and shift register, all asynchronously.
REQ-027 SHALL abort a frame on reset mid-frame with no partial frame resumed; the first edge after release is in IDLE and can accept a byte.

Structure
REQ-028 SHALL place the FSM state enum type and the parity function in shared package uart_pkg, which uart_rx also uses.
REQ-029 SHALL instantiate one sub-module, uart_baud_gen (bit-cycle counter with a clear input and a bit_done output), parameterized by CLKS_PER_BIT.

Verification
REQ-030 SHALL verify: CLKS_PER_BIT=4, even parity, send 0xA5 -> tx_o bits 0,1,0,1,0,0,1,0,1,0,1, each 4 cycles; 44-cycle frame; tready low for 44 cycles.
REQ-031 SHALL verify: send 0x01 even, then 0x01 with PARITY_ODD=1 -> parity bit 1, then 0.
REQ-032 SHALL verify: tvalid held high with 0x55 then 0xAA queued -> second handshake exactly 45 cycles after the first; frames contiguous except 1 extra idle-high cycle.
REQ-033 SHALL verify: assert rst_n_i during the DATA_BIT of 0xFF -> tx_o = 1 and tready = 1 immediately; a subsequent 0x3C frame is correct.
REQ-034 SHALL verify: PARITY_EN=0 with 0x80 -> 10-bit frame 0,0,0,0,0,0,0,0,1,1; tdata changed mid-frame is not transmitted.
